// File: rtl/register_scoreboard.sv
// register_scoreboard: pending-write tracker between ID (issue) and WB (retire).
// ID marks a destination pending on issue, WB clears it on retire, and ID is
// stalled when a live source is pending or the destination counter is full.
// Optional build macro SCOREBOARD_STATS_EN adds stall/issue statistics counters.
module register_scoreboard #(
    parameter int NUM_REGS = 16,
    parameter int CNT_W    = 2
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [$clog2(NUM_REGS)-1:0] i_src1,
    input  logic [$clog2(NUM_REGS)-1:0] i_src2,
    input  logic                        i_is_imm,
    input  logic                        i_is_str,
    input  logic                        i_issue_valid,
    input  logic                        i_issue_wb_en,
    input  logic [$clog2(NUM_REGS)-1:0] i_issue_dest,
    input  logic                        i_freeze,
    input  logic                        i_wb_valid,
    input  logic [$clog2(NUM_REGS)-1:0] i_wb_dest,
    output logic                        o_stall,
    output logic                        o_issue_fire,
    output logic [NUM_REGS-1:0]         o_busy_mask,
`ifdef SCOREBOARD_STATS_EN
    output logic [31:0]                 o_stall_cycles,
    output logic [31:0]                 o_issue_count,
`endif
    output logic                        o_err_underflow
);
    localparam int RW = $clog2(NUM_REGS);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]    r_cnt [NUM_REGS];
    logic                r_err;
    logic [NUM_REGS-1:0] w_busy;
    logic [NUM_REGS-1:0] w_inc;
    logic [NUM_REGS-1:0] w_dec;
    logic                w_src2_live;
    logic                w_haz;
    logic                w_sat;
    logic                w_stall;
    logic                w_fire;
    logic                w_uflow;

    // Busy view of the registered counters; hazards never see same-cycle WB.
    always_comb begin
        w_busy = '0;
        for (int r = 0; r < NUM_REGS; r++)
            w_busy[r] = (r_cnt[r] != '0);
    end

    // Issue-side hazard, saturation stall and issue acceptance.
    always_comb begin
        w_src2_live = ~i_is_imm | i_is_str;
        w_haz   = i_issue_valid & (w_busy[i_src1] | (w_src2_live & w_busy[i_src2]));
        w_sat   = i_issue_valid & i_issue_wb_en & (r_cnt[i_issue_dest] == CNT_MAX);
        w_stall = w_haz | w_sat;
        w_fire  = i_issue_valid & ~w_stall & ~i_freeze;
    end

    // Per-register increment/decrement; a WB meeting a same-cycle issue at
    // zero cancels it rather than flagging underflow.
    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            w_inc[r] = w_fire & i_issue_wb_en & (i_issue_dest == RW'(r));
            w_dec[r] = i_wb_valid & (i_wb_dest == RW'(r)) &
                       ((r_cnt[r] != '0) | w_inc[r]);
        end
        w_uflow = i_wb_valid & (r_cnt[i_wb_dest] == '0) & ~w_inc[i_wb_dest];
    end

    // Counter state; saturation stall keeps increments from wrapping.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            for (int r = 0; r < NUM_REGS; r++)
                r_cnt[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (w_inc[r] & ~w_dec[r])
                    r_cnt[r] <= r_cnt[r] + 1'b1;
                else if (w_dec[r] & ~w_inc[r])
                    r_cnt[r] <= r_cnt[r] - 1'b1;
            end
        end
    end

    // Sticky underflow flag, cleared only by reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst)
            r_err <= 1'b0;
        else if (w_uflow)
            r_err <= 1'b1;
    end

`ifdef SCOREBOARD_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_issue_count;

    // Saturating statistics counters.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_stall_cycles <= '0;
            r_issue_count  <= '0;
        end else begin
            if (i_issue_valid & w_stall & (r_stall_cycles != '1))
                r_stall_cycles <= r_stall_cycles + 32'd1;
            if (w_fire & (r_issue_count != '1))
                r_issue_count <= r_issue_count + 32'd1;
        end
    end

    assign o_stall_cycles = r_stall_cycles;
    assign o_issue_count  = r_issue_count;
`endif

    assign o_stall         = w_stall;
    assign o_issue_fire    = w_fire;
    assign o_busy_mask     = w_busy;
    assign o_err_underflow = r_err;
endmodule

// File: tb/tb_register_scoreboard.sv
// Self-checking bench for register_scoreboard: directed scenarios with literal
// expectations plus a per-cycle comparison against a counter-array model.
module tb_register_scoreboard;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  src1, src2, issue_dest, wb_dest;
    logic        is_imm, is_str, issue_valid, issue_wb_en, freeze, wb_valid;
    logic        stall, issue_fire, err_underflow;
    logic [15:0] busy_mask;
`ifdef SCOREBOARD_STATS_EN
    logic [31:0] stall_cycles, issue_count;
`endif

    register_scoreboard #(.NUM_REGS(16), .CNT_W(2)) dut (
        .i_clk(clk), .i_rst(rst), .i_src1(src1), .i_src2(src2),
        .i_is_imm(is_imm), .i_is_str(is_str), .i_issue_valid(issue_valid),
        .i_issue_wb_en(issue_wb_en), .i_issue_dest(issue_dest), .i_freeze(freeze),
        .i_wb_valid(wb_valid), .i_wb_dest(wb_dest), .o_stall(stall),
        .o_issue_fire(issue_fire), .o_busy_mask(busy_mask),
`ifdef SCOREBOARD_STATS_EN
        .o_stall_cycles(stall_cycles), .o_issue_count(issue_count),
`endif
        .o_err_underflow(err_underflow));

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    // Model: number of writes in flight per register, sticky error, stats.
    int     m_cnt [16];
    bit     m_err;
    bit     m_known = 0;
    longint m_sc, m_ic;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Compare at negedge against the model, then advance the model to what
    // the coming posedge must produce.
    task automatic tick();
        bit e_haz, e_sat, e_stall, e_fire, live;
        logic [15:0] e_busy;
        int pre;
        @(negedge clk);
        live    = !is_imm || is_str;
        e_haz   = issue_valid && (m_cnt[src1] > 0 || (live && m_cnt[src2] > 0));
        e_sat   = issue_valid && issue_wb_en && m_cnt[issue_dest] == 3;
        e_stall = e_haz || e_sat;
        e_fire  = issue_valid && !e_stall && !freeze;
        for (int r = 0; r < 16; r++) e_busy[r] = (m_cnt[r] != 0);
        if (m_known) begin
            chk("stall", 32'(stall), 32'(e_stall));
            chk("issue_fire", 32'(issue_fire), 32'(e_fire));
            chk("busy_mask", 32'(busy_mask), 32'(e_busy));
            chk("err_underflow", 32'(err_underflow), 32'(m_err));
`ifdef SCOREBOARD_STATS_EN
            chk("stall_cycles", stall_cycles, 32'(m_sc));
            chk("issue_count", issue_count, 32'(m_ic));
`endif
        end
        if (!rst) begin
            for (int r = 0; r < 16; r++) m_cnt[r] = 0;
            m_err = 0; m_sc = 0; m_ic = 0; m_known = 1;
        end else begin
            pre = m_cnt[wb_dest];
            if (e_fire && issue_wb_en) m_cnt[issue_dest]++;
            if (wb_valid) begin
                if (pre > 0 || (e_fire && issue_wb_en && issue_dest == wb_dest))
                    m_cnt[wb_dest]--;
                else
                    m_err = 1;
            end
            if (issue_valid && e_stall && m_sc < 64'hFFFF_FFFF) m_sc++;
            if (e_fire && m_ic < 64'hFFFF_FFFF) m_ic++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        src1 = 0; src2 = 0; is_imm = 0; is_str = 0; issue_valid = 0;
        issue_wb_en = 0; issue_dest = 0; freeze = 0; wb_valid = 0; wb_dest = 0;
    endtask

    task automatic issue(input logic [3:0] d);
        idle(); issue_valid = 1; issue_wb_en = 1; issue_dest = d;
    endtask

    initial begin
        idle(); rst = 0;
        tick(); tick();
        rst = 1; #1;
        // 1. reset state
        chk("rst_busy", 32'(busy_mask), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_err", 32'(err_underflow), 32'h0);

        // 2. issue r3 then read it
        issue(3); #1;
        chk("r3_fire", 32'(issue_fire), 32'h1);
        tick();
        idle(); issue_valid = 1; src1 = 3; #1;
        chk("r3_stall_c1", 32'(stall), 32'h1);
        chk("r3_busy_c1", 32'(busy_mask), 32'h0008);
        tick();
        wb_valid = 1; wb_dest = 3; #1;
        chk("r3_stall_c2_nobypass", 32'(stall), 32'h1);
        tick();
        wb_valid = 0; #1;
        chk("r3_stall_c3", 32'(stall), 32'h0);
        tick();

        // 3. immediate vs store on src2
        issue(5); tick();
        idle(); issue_valid = 1; src2 = 5; is_imm = 1; is_str = 0; #1;
        chk("imm_no_stall", 32'(stall), 32'h0);
        tick();
        is_str = 1; #1;
        chk("str_stall", 32'(stall), 32'h1);
        tick();
        idle(); wb_valid = 1; wb_dest = 5; tick();

        // 4. saturation on r7
        issue(7); tick(); tick(); tick();
        #1;
        chk("sat_busy7", 32'(busy_mask), 32'h0080);
        chk("sat_stall", 32'(stall), 32'h1);
        chk("sat_nofire", 32'(issue_fire), 32'h0);
        tick();
        wb_valid = 1; wb_dest = 7; #1;
        chk("sat_stall_wb", 32'(stall), 32'h1);
        tick();
        wb_valid = 0; #1;
        chk("sat_fire_after_wb", 32'(issue_fire), 32'h1);
        tick();
        idle(); wb_valid = 1; wb_dest = 7;
        tick(); tick(); tick();
        idle(); #1;
        chk("sat_drained", 32'(busy_mask), 32'h0);

        // 5. simultaneous issue+WB from zero, then underflow
        issue(2); wb_valid = 1; wb_dest = 2; #1;
        chk("sim_fire", 32'(issue_fire), 32'h1);
        tick();
        idle(); #1;
        chk("sim_busy", 32'(busy_mask), 32'h0);
        chk("sim_noerr", 32'(err_underflow), 32'h0);
        wb_valid = 1; wb_dest = 9; tick();
        idle(); #1;
        chk("uflow_set", 32'(err_underflow), 32'h1);
        tick(); tick();
        chk("uflow_sticky", 32'(err_underflow), 32'h1);

        // 6a. freeze blocks issue
        issue(4); freeze = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("frz_nofire", 32'(issue_fire), 32'h0);
            tick();
        end
        idle(); #1;
        chk("frz_nochange", 32'(busy_mask), 32'h0);

        // Pseudo-random traffic checked by the model every cycle.
        for (int i = 0; i < 300; i++) begin
            idle();
            issue_valid = ($urandom_range(0, 9) < 7);
            issue_wb_en = ($urandom_range(0, 3) != 0);
            issue_dest  = 4'($urandom_range(0, 7));
            src1   = 4'($urandom_range(0, 15));
            src2   = 4'($urandom_range(0, 15));
            is_imm = ($urandom_range(0, 1) == 1);
            is_str = ($urandom_range(0, 3) == 0);
            freeze = ($urandom_range(0, 6) == 0);
            wb_valid = ($urandom_range(0, 9) < 5);
            wb_dest  = 4'($urandom_range(0, 7));
            tick();
        end

        // 6b. reset clears everything; stats over a fresh run
        idle(); rst = 0; tick(); rst = 1; #1;
        chk("rst2_busy", 32'(busy_mask), 32'h0);
        chk("rst2_err", 32'(err_underflow), 32'h0);
        issue(6); tick();
        idle(); issue_valid = 1; src1 = 6;
        tick(); tick(); tick();
        idle(); #1;
`ifdef SCOREBOARD_STATS_EN
        chk("stats_stall_cycles", stall_cycles, 32'd3);
        chk("stats_issue_count", issue_count, 32'd1);
`endif
        chk("r6_busy", 32'(busy_mask), 32'h0040);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
